// File: rtl/cnt_pkg.sv
// Shared definitions for the counter preload sequencer.
// Holds the counter width, default queue depth and the sequencer state type.
package cnt_pkg;

    localparam int CNT_W         = 4;
    localparam int DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/preload_fifo.sv
// Single-clock FIFO with a show-ahead head for queued counter presets.
// Ports: clk, reset (sync, active-high), push/wdata in, pop in,
//        rdata (head), level, full, empty out.
module preload_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by r_level.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr];
    assign level = r_level;
    assign full  = (r_level == (AW+1)'(DEPTH));
    assign empty = (r_level == '0);

endmodule

// File: rtl/cnt_preload_seq.sv
// Preload sequencer: queues preset values and pulses load/din into the
// 4-bit counter whenever its output equals match, one segment per preset.
// Ports: clk, reset (sync, active-high), enable, s_valid/s_ready/s_data
//        stream in, cnt_in, match; load, din, level, underrun, busy out.
module cnt_preload_seq
    import cnt_pkg::*;
#(
    parameter int W     = CNT_W,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [W-1:0]           s_data,
    input  logic [W-1:0]           cnt_in,
    input  logic [W-1:0]           match,
    output logic                   load,
    output logic [W-1:0]           din,
    output logic [$clog2(DEPTH):0] level,
    output logic                   underrun,
    output logic                   busy
);

    seq_state_t r_state;
    seq_state_t w_state_nxt;

    logic         r_load;
    logic [W-1:0] r_din;
    logic         r_underrun;

    logic         w_push;
    logic         w_pop;
    logic         w_hit;
    logic         w_load_nxt;
    logic         w_underrun_set;
    logic         w_full;
    logic         w_empty;
    logic [W-1:0] w_head;

    // s_ready comes from registered level only, so no path from s_valid.
    assign s_ready = !w_full;
    assign w_push  = s_valid && s_ready;
    assign w_hit   = enable && (cnt_in == match);

    preload_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .wdata (s_data),
        .pop   (w_pop),
        .rdata (w_head),
        .level (level),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ARMED;
        else       r_state <= w_state_nxt;
    end

    // LOAD and SETTLE ignore enable and cnt_in: once started, a load
    // always runs to completion, and SETTLE masks the stale cnt_in.
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_load_nxt     = 1'b0;
        w_underrun_set = 1'b0;
        unique case (r_state)
            ARMED: begin
                if (w_hit) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_load_nxt  = 1'b1;
                        w_state_nxt = LOAD;
                    end else begin
                        w_underrun_set = 1'b1;
                    end
                end
            end
            LOAD:    w_state_nxt = SETTLE;
            SETTLE:  w_state_nxt = ARMED;
            default: w_state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_load     <= 1'b0;
            r_din      <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_load <= w_load_nxt;
            if (w_pop)          r_din      <= w_head;
            if (w_underrun_set) r_underrun <= 1'b1;
        end
    end

    assign load     = r_load;
    assign din      = r_din;
    assign underrun = r_underrun;
    assign busy     = (r_state != ARMED);

endmodule

// File: tb/tb_cnt_preload_seq.sv
// Directed bench for cnt_preload_seq with a behavioral loadable counter.
// Inputs change just after posedge or at negedge; outputs sampled at negedge.
module tb_cnt_preload_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] s_data;
    logic [3:0] cnt_in;
    logic [3:0] match;
    logic       load;
    logic [3:0] din;
    logic [2:0] level;
    logic       underrun;
    logic       busy;

    logic [3:0] r_cnt;
    logic       force_en;
    logic [3:0] force_val;
    int         cyc;
    int         nload;
    int         n_cmp;
    int         n_bad;
    int         c0;
    int         l0;

    always #5 clk = ~clk;

    cnt_preload_seq dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .cnt_in   (cnt_in),
        .match    (match),
        .load     (load),
        .din      (din),
        .level    (level),
        .underrun (underrun),
        .busy     (busy)
    );

    // Downstream 4-bit loadable counter; cnt_in can be pinned by the bench.
    always @(posedge clk) begin
        if (reset)     r_cnt <= 4'h0;
        else if (load) r_cnt <= din;
        else           r_cnt <= r_cnt + 4'h1;
    end

    assign cnt_in = force_en ? force_val : r_cnt;

    initial begin
        cyc   = 0;
        nload = 0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load) nload <= nload + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        enable   = 1'b0;
        s_valid  = 1'b0;
        s_data   = 4'h0;
        force_en = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic push(input logic [3:0] v);
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = v;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("push_timeout", 32'(ok), 32'd1);
        else     tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_cnt(input logic [3:0] v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (cnt_in == v) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("cnt_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_load();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (load) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("load_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        match     = 4'h0;
        force_val = 4'h0;

        // Reset state, then idle with empty FIFO -> underrun, no load.
        do_reset();
        @(negedge clk);
        check("rst_level",    32'(level),    32'd0);
        check("rst_s_ready",  32'(s_ready),  32'd1);
        check("rst_load",     32'(load),     32'd0);
        check("rst_din",      32'(din),      32'h0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        match  = 4'h5;
        enable = 1'b1;
        l0     = nload;
        wait_cnt(4'h5);
        check("idle_unr_pre", 32'(underrun), 32'd0);
        @(negedge clk);
        check("idle_unr",     32'(underrun), 32'd1);
        check("idle_noload",  32'(nload - l0), 32'd0);
        check("idle_s_ready", 32'(s_ready),  32'd1);
        check("idle_busy",    32'(busy),     32'd0);

        // Two presets A, 2 with match 7.
        do_reset();
        match = 4'h7;
        push(4'hA);
        push(4'h2);
        @(negedge clk);
        check("q2_level", 32'(level), 32'd2);
        enable = 1'b1;
        l0     = nload;
        wait_cnt(4'h7);
        check("q2_load_pre", 32'(load), 32'd0);
        @(negedge clk);
        check("q2_load1",  32'(load),   32'd1);
        check("q2_din1",   32'(din),    32'hA);
        check("q2_cnt8",   32'(cnt_in), 32'h8);
        check("q2_level1", 32'(level),  32'd1);
        check("q2_busy_l", 32'(busy),   32'd1);
        @(negedge clk);
        check("q2_load_off", 32'(load),   32'd0);
        check("q2_cntA",     32'(cnt_in), 32'hA);
        check("q2_busy_s",   32'(busy),   32'd1);
        @(negedge clk);
        check("q2_cntB",   32'(cnt_in), 32'hB);
        check("q2_busy_a", 32'(busy),   32'd0);
        wait_cnt(4'h7);
        @(negedge clk);
        check("q2_load2",  32'(load),  32'd1);
        check("q2_din2",   32'(din),   32'h2);
        check("q2_level0", 32'(level), 32'd0);
        @(negedge clk);
        check("q2_nload", 32'(nload - l0), 32'd2);
        check("q2_unr",   32'(underrun),   32'd0);

        // Five pushes into DEPTH 4: fifth held until a pop frees a slot.
        do_reset();
        match = 4'h0;
        push(4'h1);
        push(4'h2);
        push(4'h3);
        push(4'h4);
        @(negedge clk);
        check("full_level",   32'(level),   32'd4);
        check("full_s_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b1;
        s_data  = 4'h5;
        repeat (2) @(negedge clk);
        check("full_hold", 32'(level), 32'd4);
        enable = 1'b1;
        wait_load();
        check("full_din1",   32'(din),     32'h1);
        check("full_lvl3",   32'(level),   32'd3);
        check("full_ready1", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        check("full_refill", 32'(level), 32'd4);
        for (int k = 2; k <= 5; k++) begin
            wait_load();
            check($sformatf("full_order%0d", k), 32'(din), 32'(k));
        end
        check("full_drain", 32'(level), 32'd0);

        // True push+pop in one edge; enable dropped during LOAD.
        do_reset();
        match = 4'h6;
        push(4'h7);
        push(4'h8);
        push(4'h9);
        enable = 1'b1;
        wait_cnt(4'h6);
        s_valid = 1'b1;
        s_data  = 4'hC;
        tick();
        s_valid = 1'b0;
        enable  = 1'b0;
        @(negedge clk);
        check("pp_load",  32'(load),  32'd1);
        check("pp_din",   32'(din),   32'h7);
        check("pp_level", 32'(level), 32'd3);
        @(negedge clk);
        check("pp_settle_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("pp_armed_busy",  32'(busy), 32'd0);
        enable = 1'b1;
        wait_load();
        check("pp_order8", 32'(din), 32'h8);
        wait_load();
        check("pp_order9", 32'(din), 32'h9);
        wait_load();
        check("pp_orderC", 32'(din), 32'hC);

        // cnt_in pinned at match: loads 3 cycles apart, no SETTLE retrigger.
        do_reset();
        match = 4'h3;
        push(4'h3);
        push(4'h3);
        force_val = 4'h3;
        force_en  = 1'b1;
        l0        = nload;
        enable    = 1'b1;
        wait_load();
        c0 = cyc;
        check("eq_din1", 32'(din), 32'h3);
        @(negedge clk);
        check("eq_gap1", 32'(load), 32'd0);
        @(negedge clk);
        check("eq_gap2", 32'(load), 32'd0);
        wait_load();
        check("eq_spacing", 32'(cyc - c0), 32'd3);
        check("eq_level0",  32'(level),    32'd0);
        repeat (3) @(negedge clk);
        check("eq_nload", 32'(nload - l0), 32'd2);
        check("eq_unr",   32'(underrun),   32'd1);
        force_en = 1'b0;

        // Terminal count trigger and underrun on F->0 wrap.
        do_reset();
        match = 4'hF;
        push(4'h9);
        enable = 1'b1;
        wait_cnt(4'hF);
        @(negedge clk);
        check("wrap_load", 32'(load),   32'd1);
        check("wrap_din",  32'(din),    32'h9);
        check("wrap_cnt0", 32'(cnt_in), 32'h0);
        wait_cnt(4'hF);
        check("wrap_unr_pre", 32'(underrun), 32'd0);
        @(negedge clk);
        check("wrap_unr",   32'(underrun), 32'd1);
        check("wrap_cnt",   32'(cnt_in),   32'h0);
        check("wrap_noload", 32'(load),    32'd0);

        // Reset while in LOAD with three entries still queued.
        do_reset();
        match = 4'h4;
        push(4'h1);
        push(4'h2);
        push(4'h3);
        push(4'h4);
        enable = 1'b1;
        wait_load();
        check("rl_level_pre", 32'(level), 32'd3);
        reset = 1'b1;
        tick();
        check("rl_load",     32'(load),     32'd0);
        check("rl_level",    32'(level),    32'd0);
        check("rl_din",      32'(din),      32'h0);
        check("rl_underrun", 32'(underrun), 32'd0);
        check("rl_cnt",      32'(cnt_in),   32'h0);
        check("rl_busy",     32'(busy),     32'd0);
        reset = 1'b0;
        tick(3);
        check("rl_no_pending", 32'(load), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
